// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: 2-flop synchronized mid-bit-sampling UART receiver with a FWFT byte FIFO.
// Define UART_RX_MONITOR_PARITY_EN for 8E1 framing with an o_parity_err pulse (default 8N1).
module uart_rx_monitor #(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_rx,
    output logic [7:0]                    o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_busy,
    output logic                          o_frame_err,
    output logic                          o_overflow,
`ifdef UART_RX_MONITOR_PARITY_EN
    output logic                          o_parity_err,
`endif
    input  logic                          i_clr_overflow
);
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam int CNTW         = AW + 1;
    localparam logic [CW-1:0]   BIT_RELOAD  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]   CNT_ZERO    = {CW{1'b0}};
    localparam logic [CNTW-1:0] FULL_COUNT  = CNTW'(FIFO_DEPTH);
    localparam logic [CNTW-1:0] EMPTY_COUNT = {CNTW{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
`ifdef UART_RX_MONITOR_PARITY_EN
        ST_PARITY    = 3'd3,
`endif
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    logic          sync1_q, sync2_q, rx_s;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          frame_err_q, frame_err_d;
    logic          push_s;
`ifdef UART_RX_MONITOR_PARITY_EN
    logic          par_bad_q, par_bad_d;
    logic          parity_err_q, parity_err_d;

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction
`endif

    // Two-flop synchronizer, reset to the idle-high line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= i_rx;
            sync2_q <= sync1_q;
        end
    end
    assign rx_s = sync2_q;

    // RX next-state logic; push_s fires on a good stop-bit sample.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push_s      = 1'b0;
`ifdef UART_RX_MONITOR_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    cnt_d   = HALF_RELOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!rx_s) begin
                    state_d   = ST_DATA;
                    cnt_d     = BIT_RELOAD;
                    bit_idx_d = 3'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    cnt_d     = BIT_RELOAD;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_MONITOR_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
`ifdef UART_RX_MONITOR_PARITY_EN
            ST_PARITY: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    par_bad_d = (even_parity(shift_q) != rx_s);
                    cnt_d     = BIT_RELOAD;
                    state_d   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
`ifdef UART_RX_MONITOR_PARITY_EN
                    parity_err_d = par_bad_q;
`endif
                    // Return to IDLE mid-stop-bit so an immediate next start edge is seen.
                    if (rx_s) begin
`ifdef UART_RX_MONITOR_PARITY_EN
                        push_s = ~par_bad_q;
`else
                        push_s = 1'b1;
`endif
                        state_d = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // RX state registers and registered error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= CNT_ZERO;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'd0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_MONITOR_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_MONITOR_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0] count_q, count_d;
    logic            pop_s, full_s, accept_s, ovf_set_s;
    logic            overflow_q, overflow_d;

    // FIFO control: a push into a full FIFO is still accepted when a pop frees a slot.
    always_comb begin
        pop_s      = (count_q != EMPTY_COUNT) && i_ready;
        full_s     = (count_q == FULL_COUNT);
        accept_s   = push_s && (!full_s || pop_s);
        ovf_set_s  = push_s && full_s && !pop_s;
        overflow_d = (overflow_q && !i_clr_overflow) || ovf_set_s;
        if (accept_s && !pop_s) begin
            count_d = count_q + CNTW'(1);
        end else if (pop_s && !accept_s) begin
            count_d = count_q - CNTW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // FIFO storage, pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'd0;
            end
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= EMPTY_COUNT;
            overflow_q <= 1'b0;
        end else begin
            if (accept_s) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_data      = mem_q[rd_ptr_q];
    assign o_valid     = (count_q != EMPTY_COUNT);
    assign o_count     = count_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_frame_err = frame_err_q;
    assign o_overflow  = overflow_q;
`ifdef UART_RX_MONITOR_PARITY_EN
    assign o_parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Self-checking bench for uart_rx_monitor: 10 clocks per bit, byte-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_monitor;
    localparam int CLK_FREQ_HZ = 1000000;
    localparam int BAUD        = 100000;
    localparam int FIFO_DEPTH  = 8;
    localparam int CPB         = CLK_FREQ_HZ / BAUD;

    logic                        clk = 1'b0;
    logic                        rst_n, i_rx, i_ready, i_clr_overflow;
    logic [7:0]                  o_data;
    logic                        o_valid, o_busy, o_frame_err, o_overflow;
    logic [$clog2(FIFO_DEPTH):0] o_count;
`ifdef UART_RX_MONITOR_PARITY_EN
    logic                        o_parity_err;
`endif

    uart_rx_monitor #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ), .BAUD(BAUD), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_rx(i_rx),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
        .o_count(o_count), .o_busy(o_busy), .o_frame_err(o_frame_err),
        .o_overflow(o_overflow),
`ifdef UART_RX_MONITOR_PARITY_EN
        .o_parity_err(o_parity_err),
`endif
        .i_clr_overflow(i_clr_overflow)
    );

    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Observed side: bytes consumed, valid cycles and error pulses.
    logic [7:0] got_q[$];
    int valid_cyc = 0;
    int fe_cnt    = 0;
    int pe_cnt    = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_valid) valid_cyc++;
            if (o_valid && i_ready) got_q.push_back(o_data);
            if (o_frame_err) fe_cnt++;
`ifdef UART_RX_MONITOR_PARITY_EN
            if (o_parity_err) pe_cnt++;
`endif
        end
    end

    // Reference model: bytes expected in consumption order plus error tallies.
    logic [7:0] exp_q[$];
    int exp_held = 0;
    int exp_fe   = 0;
    int exp_pe   = 0;
    logic exp_ovf = 1'b0;

    task automatic model_frame(input logic [7:0] b, input logic stop_ok, input logic par_ok);
        if (!stop_ok) exp_fe++;
        else if (!par_ok) exp_pe++;
        else if (i_ready) exp_q.push_back(b);
        else if (exp_held < FIFO_DEPTH) begin
            exp_q.push_back(b);
            exp_held++;
        end else exp_ovf = 1'b1;
    endtask

    task automatic model_reset();
        repeat (exp_held) void'(exp_q.pop_back());
        exp_held = 0;
        exp_ovf  = 1'b0;
    endtask

    function automatic logic [8:0] got_at(input int idx);
        if (idx < got_q.size()) return {1'b1, got_q[idx]};
        return 9'h000;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        i_rx = v;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_MONITOR_PARITY_EN
        drive_bit((^b) ^ ~par_ok);
`endif
        drive_bit(stop_bit);
        model_frame(b, stop_bit, par_ok);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_rx = 1'b1; i_ready = 1'b0; i_clr_overflow = 1'b0;
        tick(3);
        chk_cnt++; if (o_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", o_valid); else pass_cnt++;
        chk_cnt++; if (o_count !== 4'd0) $display("FAIL reset_count: got %0d want 0", o_count); else pass_cnt++;
        chk_cnt++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_busy); else pass_cnt++;
        chk_cnt++; if (o_frame_err !== 1'b0) $display("FAIL reset_ferr: got %b want 0", o_frame_err); else pass_cnt++;
        chk_cnt++; if (o_overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", o_overflow); else pass_cnt++;
        chk_cnt++; if (o_data !== 8'h00) $display("FAIL reset_data: got %h want 00", o_data); else pass_cnt++;
        rst_n = 1'b1;
        tick(CPB);
    endtask

    task automatic test_back_to_back();
        int base = got_q.size();
        int vb = valid_cyc;
        int fb = fe_cnt;
        i_ready = 1'b1;
        send_frame(8'h55, 1'b1, 1'b1);
        send_frame(8'hA3, 1'b1, 1'b1);
        tick(2 * CPB);
        chk_cnt++; if (got_q.size() !== exp_q.size()) $display("FAIL b2b_size: got %0d want %0d", got_q.size(), exp_q.size()); else pass_cnt++;
        for (int i = base; i < exp_q.size(); i++) begin
            chk_cnt++; if (got_at(i) !== {1'b1, exp_q[i]}) $display("FAIL b2b_byte%0d: got %h want %h", i, got_at(i), exp_q[i]); else pass_cnt++;
        end
        chk_cnt++; if (valid_cyc - vb !== 2) $display("FAIL b2b_valid_cycles: got %0d want 2", valid_cyc - vb); else pass_cnt++;
        chk_cnt++; if (fe_cnt - fb !== 0) $display("FAIL b2b_ferr: got %0d want 0", fe_cnt - fb); else pass_cnt++;
    endtask

    task automatic test_glitch();
        int base = got_q.size();
        int fb = fe_cnt;
        int k;
        i_rx = 1'b0;
        tick(3);
        i_rx = 1'b1;
        chk_cnt++; if (o_busy !== 1'b1) $display("FAIL glitch_busy_seen: got %b want 1", o_busy); else pass_cnt++;
        for (k = 0; k < 6; k++) begin
            if (o_busy === 1'b0) break;
            tick(1);
        end
        chk_cnt++; if (o_busy !== 1'b0) $display("FAIL glitch_busy_clear: got %b want 0 after %0d cycles", o_busy, k); else pass_cnt++;
        tick(2 * CPB);
        chk_cnt++; if (got_q.size() !== base) $display("FAIL glitch_no_push: got %0d bytes want %0d", got_q.size(), base); else pass_cnt++;
        chk_cnt++; if (fe_cnt - fb !== 0) $display("FAIL glitch_ferr: got %0d want 0", fe_cnt - fb); else pass_cnt++;
    endtask

    task automatic test_frame_err();
        int base = got_q.size();
        int fb = fe_cnt;
        int eb = exp_fe;
        send_frame(8'h3C, 1'b0, 1'b1);
        tick(30);
        i_rx = 1'b1;
        tick(CPB);
        send_frame(8'h7E, 1'b1, 1'b1);
        tick(2 * CPB);
        chk_cnt++; if (fe_cnt - fb !== exp_fe - eb) $display("FAIL ferr_pulses: got %0d want %0d", fe_cnt - fb, exp_fe - eb); else pass_cnt++;
        chk_cnt++; if (got_q.size() !== exp_q.size()) $display("FAIL ferr_size: got %0d want %0d", got_q.size(), exp_q.size()); else pass_cnt++;
        for (int i = base; i < exp_q.size(); i++) begin
            chk_cnt++; if (got_at(i) !== {1'b1, exp_q[i]}) $display("FAIL ferr_byte%0d: got %h want %h", i, got_at(i), exp_q[i]); else pass_cnt++;
        end
    endtask

    task automatic test_overflow();
        int base = got_q.size();
        i_ready = 1'b0;
        for (int v = 1; v <= 9; v++) send_frame(8'(v), 1'b1, 1'b1);
        tick(2 * CPB);
        chk_cnt++; if (o_count !== 4'(exp_held)) $display("FAIL ovf_count: got %0d want %0d", o_count, exp_held); else pass_cnt++;
        chk_cnt++; if (o_overflow !== exp_ovf) $display("FAIL ovf_flag: got %b want %b", o_overflow, exp_ovf); else pass_cnt++;
        chk_cnt++; if ({o_valid, o_data} !== {1'b1, exp_q[base]}) $display("FAIL ovf_head: got %b/%h want 1/%h", o_valid, o_data, exp_q[base]); else pass_cnt++;
        i_ready = 1'b1;
        exp_held = 0;
        for (int k = 0; k < 40 && got_q.size() < exp_q.size(); k++) tick(1);
        tick(2);
        chk_cnt++; if (got_q.size() !== exp_q.size()) $display("FAIL ovf_drain_size: got %0d want %0d", got_q.size(), exp_q.size()); else pass_cnt++;
        for (int i = base; i < exp_q.size(); i++) begin
            chk_cnt++; if (got_at(i) !== {1'b1, exp_q[i]}) $display("FAIL ovf_byte%0d: got %h want %h", i, got_at(i), exp_q[i]); else pass_cnt++;
        end
        chk_cnt++; if (o_count !== 4'd0) $display("FAIL ovf_drained_count: got %0d want 0", o_count); else pass_cnt++;
        chk_cnt++; if (o_overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", o_overflow); else pass_cnt++;
        i_clr_overflow = 1'b1;
        tick(1);
        i_clr_overflow = 1'b0;
        exp_ovf = 1'b0;
        chk_cnt++; if (o_overflow !== exp_ovf) $display("FAIL ovf_clear: got %b want %b", o_overflow, exp_ovf); else pass_cnt++;
    endtask

    task automatic test_reset_mid_byte();
        int base;
        i_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b1);
        tick(CPB);
        chk_cnt++; if (o_count !== 4'(exp_held)) $display("FAIL rst_pre_count: got %0d want %0d", o_count, exp_held); else pass_cnt++;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        tick(5);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_cnt++; if (o_busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", o_busy); else pass_cnt++;
        chk_cnt++; if (o_count !== 4'd0) $display("FAIL rst_mid_count: got %0d want 0", o_count); else pass_cnt++;
        chk_cnt++; if (o_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", o_valid); else pass_cnt++;
        chk_cnt++; if (o_data !== 8'h00) $display("FAIL rst_mid_data: got %h want 00", o_data); else pass_cnt++;
        tick(3);
        rst_n = 1'b1;
        tick(2 * CPB);
        i_ready = 1'b1;
        base = got_q.size();
        send_frame(8'h42, 1'b1, 1'b1);
        tick(2 * CPB);
        chk_cnt++; if (got_q.size() !== exp_q.size()) $display("FAIL rst_mid_size: got %0d want %0d", got_q.size(), exp_q.size()); else pass_cnt++;
        for (int i = base; i < exp_q.size(); i++) begin
            chk_cnt++; if (got_at(i) !== {1'b1, exp_q[i]}) $display("FAIL rst_mid_byte%0d: got %h want %h", i, got_at(i), exp_q[i]); else pass_cnt++;
        end
    endtask

    task automatic test_random();
        int base = got_q.size();
        int fb = fe_cnt;
        int eb = exp_fe;
        logic [7:0] b;
        logic stop_ok;
        i_ready = 1'b1;
        for (int n = 0; n < 16; n++) begin
            b = 8'($urandom);
            stop_ok = ($urandom_range(0, 3) != 0);
            send_frame(b, stop_ok, 1'b1);
            if (!stop_ok) begin
                i_rx = 1'b1;
                tick(CPB);
            end else begin
                tick($urandom_range(0, 3));
            end
        end
        tick(2 * CPB);
        chk_cnt++; if (got_q.size() !== exp_q.size()) $display("FAIL rand_size: got %0d want %0d", got_q.size(), exp_q.size()); else pass_cnt++;
        for (int i = base; i < exp_q.size(); i++) begin
            chk_cnt++; if (got_at(i) !== {1'b1, exp_q[i]}) $display("FAIL rand_byte%0d: got %h want %h", i, got_at(i), exp_q[i]); else pass_cnt++;
        end
        chk_cnt++; if (fe_cnt - fb !== exp_fe - eb) $display("FAIL rand_ferr: got %0d want %0d", fe_cnt - fb, exp_fe - eb); else pass_cnt++;
        chk_cnt++; if (o_overflow !== exp_ovf) $display("FAIL rand_ovf: got %b want %b", o_overflow, exp_ovf); else pass_cnt++;
    endtask

`ifdef UART_RX_MONITOR_PARITY_EN
    task automatic test_parity();
        int base = got_q.size();
        int pb = pe_cnt;
        int eb = exp_pe;
        i_ready = 1'b1;
        send_frame(8'h07, 1'b1, 1'b0);
        tick(CPB);
        send_frame(8'h07, 1'b1, 1'b1);
        tick(2 * CPB);
        chk_cnt++; if (pe_cnt - pb !== exp_pe - eb) $display("FAIL parity_pulses: got %0d want %0d", pe_cnt - pb, exp_pe - eb); else pass_cnt++;
        chk_cnt++; if (got_q.size() !== exp_q.size()) $display("FAIL parity_size: got %0d want %0d", got_q.size(), exp_q.size()); else pass_cnt++;
        for (int i = base; i < exp_q.size(); i++) begin
            chk_cnt++; if (got_at(i) !== {1'b1, exp_q[i]}) $display("FAIL parity_byte%0d: got %h want %h", i, got_at(i), exp_q[i]); else pass_cnt++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_overflow();
        test_reset_mid_byte();
        test_random();
`ifdef UART_RX_MONITOR_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
